// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
//   Shared types and constants for the instruction-fetch sequencer.
//   - state_t    : sequencer state encoding (BOOT/RUN/FLUSH/STALL/HALT)
//   - ctrl_t     : bundle of the per-cycle fetch control outputs
//   - PC_SRC_*   : fetch mux select polarity (1 = PC+1, 0 = jump target)
//   - DEFAULT_AW : default PC / jump target width
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  localparam int DEFAULT_AW = 8;

  // Polarity of the fetch mux select, owned by ifetch.
  localparam logic PC_SRC_SEQ = 1'b1;
  localparam logic PC_SRC_JMP = 1'b0;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    STALL = 3'd3,
    HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_src;
    logic ifid_we;
    logic ifid_flush;
    logic fetch_valid;
    logic halted;
  } ctrl_t;

  // Everything frozen: PC held, IF/ID held, nothing delivered.
  function automatic ctrl_t ctrl_hold();
    ctrl_t c;
    c.pc_we       = 1'b0;
    c.pc_src      = PC_SRC_SEQ;
    c.ifid_we     = 1'b0;
    c.ifid_flush  = 1'b0;
    c.fetch_valid = 1'b0;
    c.halted      = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/redirect_buf.sv
// -----------------------------------------------------------------------------
// redirect_buf
//   One-entry holding register for a jump that could not be taken in the cycle
//   it arrived (stall, halt or flush). A newer load overwrites the older target.
//   Ports:
//     clk         in   rising-edge clock
//     reset       in   asynchronous active-low reset
//     load        in   capture target and mark valid (wins over clear)
//     clear       in   drop the pending entry (it has been issued)
//     target      in   AW  jump target to capture
//     pend_valid  out  a jump is pending
//     pend_target out  AW  pending jump target
// -----------------------------------------------------------------------------
module redirect_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] target,
  output logic          pend_valid,
  output logic [AW-1:0] pend_target
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (load) begin
      pend_valid  <= 1'b1;
      pend_target <= target;
    end else if (clear) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Sequencer for the instruction fetch unit. After reset it waits BOOT_CYCLES
//   idle cycles, then fetches sequentially, handling hazard stalls, jump
//   redirects (followed by a one-cycle IF/ID flush of the wrong-path
//   instruction) and halt/resume. Jumps arriving while the pipe cannot take
//   them are parked in redirect_buf and issued on the first free RUN cycle.
//   Outputs are combinational from state, pending entry and inputs.
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     stall_req    in   hold PC and IF/ID this cycle
//     jump_req     in   redirect request (one-cycle pulse)
//     jump_target  in   AW  target PC, valid with jump_req
//     halt_req     in   enter HALT
//     resume       in   leave HALT
//     pc_we        out  PC register load enable
//     pc_src       out  1 = PC+1, 0 = jump target
//     pc_jump      out  AW  jump address to the fetch mux (0 when not jumping)
//     ifid_we      out  IF/ID load enable
//     ifid_flush   out  IF/ID clear (bubble insert)
//     fetch_valid  out  instruction entering IF/ID is on the correct path
//     halted       out  sequencer is in HALT
//     fetch_count  out  CW  delivered instruction count, wraps
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int AW          = DEFAULT_AW,
  parameter int BOOT_CYCLES = 2,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_req,
  input  logic          jump_req,
  input  logic [AW-1:0] jump_target,
  input  logic          halt_req,
  input  logic          resume,
  output logic          pc_we,
  output logic          pc_src,
  output logic [AW-1:0] pc_jump,
  output logic          ifid_we,
  output logic          ifid_flush,
  output logic          fetch_valid,
  output logic          halted,
  output logic [CW-1:0] fetch_count
);

  // Counter only needs to reach BOOT_CYCLES-1.
  localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

  state_t         state, state_nxt;
  logic [BCW-1:0] boot_cnt;
  ctrl_t          ctrl;
  logic           redirect;
  logic           pend_load;
  logic           pend_valid;
  logic [AW-1:0]  pend_target;

  redirect_buf #(.AW(AW)) u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (pend_load),
    .clear       (redirect),
    .target      (jump_target),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  // ---------------------------------------------------------------------------
  // Next state and per-cycle controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    ctrl      = ctrl_hold();
    state_nxt = state;
    redirect  = 1'b0;
    pend_load = 1'b0;

    case (state)
      BOOT: begin
        // Requests are ignored until the fetch path has settled.
        ctrl.ifid_flush = 1'b1;
        if (boot_cnt == BOOT_LAST) state_nxt = RUN;
      end

      RUN: begin
        if (halt_req) begin
          // Keep any coincident jump so it is not lost across the halt.
          pend_load = jump_req;
          state_nxt = HALT;
        end else if (stall_req) begin
          pend_load = jump_req;
          state_nxt = STALL;
        end else if (jump_req || pend_valid) begin
          // A live jump_req is newer than the parked one and supersedes it.
          redirect         = 1'b1;
          ctrl.pc_we       = 1'b1;
          ctrl.pc_src      = PC_SRC_JMP;
          ctrl.ifid_we     = 1'b1;
          ctrl.fetch_valid = 1'b1;
          state_nxt        = FLUSH;
        end else begin
          ctrl.pc_we       = 1'b1;
          ctrl.ifid_we     = 1'b1;
          ctrl.fetch_valid = 1'b1;
        end
      end

      FLUSH: begin
        // The instruction fetched alongside the redirect is wrong-path:
        // load IF/ID with a bubble while the PC advances from the target.
        ctrl.pc_we      = 1'b1;
        ctrl.ifid_we    = 1'b1;
        ctrl.ifid_flush = 1'b1;
        pend_load       = jump_req;
        state_nxt       = RUN;
      end

      STALL: begin
        // Latest jump during the stall wins (redirect_buf overwrites).
        pend_load = jump_req;
        if (halt_req)       state_nxt = HALT;
        else if (!stall_req) state_nxt = RUN;
      end

      HALT: begin
        ctrl.ifid_flush = 1'b1;
        ctrl.halted     = 1'b1;
        pend_load       = jump_req;
        if (resume && !halt_req) state_nxt = RUN;
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign pc_we       = ctrl.pc_we;
  assign pc_src      = ctrl.pc_src;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign fetch_valid = ctrl.fetch_valid;
  assign halted      = ctrl.halted;
  assign pc_jump     = !redirect ? '0 : (jump_req ? jump_target : pend_target);

  // ---------------------------------------------------------------------------
  // State, boot counter and delivered-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == BOOT && boot_cnt != BOOT_LAST) boot_cnt <= boot_cnt + BCW'(1);
      else                                        boot_cnt <= '0;

      // Flush cycles write IF/ID too, but with fetch_valid low, so they
      // do not count.
      if (ctrl.fetch_valid && ctrl.ifid_we) fetch_count <= fetch_count + CW'(1);
    end
  end

endmodule
